ml_frame_sequencer: RTL and testbench

Frame-level scheduler between the video frame-buffer readout, the CNN engine and the result/LED logic. Grants one frame readout at a time when code load is complete and the CNN is ready, then pulses the CNN start. Collects the N_CLASS result words and computes a registered signed argmax. Applies a consecutive-frame stability filter and a watchdog timeout so a stalled readout or inference never hangs the pipeline.

---
 rtl/ml_frame_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ml_frame_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ml_frame_sequencer.sv
// Frame-level scheduler: grants one frame readout at a time, starts the CNN,
// collects the class scores, and publishes a registered signed argmax with a stability filter and a watchdog.
module ml_frame_sequencer #(
    parameter int              N_CLASS    = 4,
    parameter int              CLS_W      = 2,
    parameter int              RES_W      = 16,
    parameter int              STABLE_MIN = 2,
    parameter int              TO_W       = 24,
    parameter logic [TO_W-1:0] TIMEOUT    = 24'd4000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load_done,
    input  logic             i_ml_rdy,
    input  logic             i_pause,
    output logic             o_rd_req,
    input  logic             i_rd_done,
    output logic             o_start,
    input  logic             i_result_en,
    input  logic [RES_W-1:0] i_result,
    output logic [CLS_W-1:0] o_class,
    output logic             o_class_vld,
    output logic [CLS_W-1:0] o_class_stable,
    output logic [3:0]       o_stable_cnt,
    output logic             o_busy,
    output logic             o_timeout,
    output logic             o_err,
    output logic [15:0]      o_frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_START,
        S_COLLECT,
        S_DECIDE
    } state_t;

    localparam logic [TO_W-1:0]  WD_LAST  = TIMEOUT - 1'b1;
    localparam logic [CLS_W-1:0] IDX_LAST = CLS_W'(N_CLASS - 1);

    state_t                  state, state_nxt;
    logic [TO_W-1:0]         wd_cnt;
    logic [CLS_W-1:0]        idx;
    logic signed [RES_W-1:0] res_mem [N_CLASS];
    logic [CLS_W-1:0]        argmax_c, argmax_q;
    logic signed [RES_W-1:0] best_val;
    logic                    decide_pend;
    logic                    wd_expire, last_word, timeout_hit;
    logic [3:0]              cnt_nxt;

    assign wd_expire = (wd_cnt == WD_LAST);
    assign last_word = i_result_en && (idx == IDX_LAST);
    assign o_busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE:    if (i_load_done && i_ml_rdy && !i_pause) state_nxt = S_REQ;
            S_REQ: begin
                if (i_rd_done) state_nxt = S_START;
                else if (wd_expire) begin
                    state_nxt   = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_START: begin
                if (wd_expire) begin
                    state_nxt   = S_IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (last_word) state_nxt = S_DECIDE;
                else if (wd_expire) begin
                    state_nxt   = S_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            S_DECIDE:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Signed argmax; strict greater-than keeps the lowest index on ties.
    always_comb begin
        argmax_c = '0;
        best_val = res_mem[0];
        for (int i = 1; i < N_CLASS; i++) begin
            if (res_mem[i] > best_val) begin
                best_val = res_mem[i];
                argmax_c = CLS_W'(i);
            end
        end
    end

    always_comb begin
        cnt_nxt = 4'd0;
        if (argmax_q == o_class && o_frame_cnt != 16'd0)
            cnt_nxt = (o_stable_cnt == 4'd15) ? 4'd15 : o_stable_cnt + 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            o_rd_req       <= 1'b0;
            o_start        <= 1'b0;
            o_timeout      <= 1'b0;
            o_err          <= 1'b0;
            o_class        <= '0;
            o_class_vld    <= 1'b0;
            o_class_stable <= '0;
            o_stable_cnt   <= 4'd0;
            o_frame_cnt    <= 16'd0;
            wd_cnt         <= '0;
            idx            <= '0;
            argmax_q       <= '0;
            decide_pend    <= 1'b0;
            // NOTE: the score store is small and must read as zero after reset, so it is cleared too.
            for (int i = 0; i < N_CLASS; i++) res_mem[i] <= '0;
        end else begin
            o_rd_req    <= (state_nxt == S_REQ);
            o_start     <= (state_nxt == S_START);
            o_timeout   <= timeout_hit;
            if (timeout_hit) o_err <= 1'b1;

            if (state_nxt == S_REQ && state != S_REQ)
                wd_cnt <= '0;
            else if (state == S_REQ || state == S_START || state == S_COLLECT)
                wd_cnt <= wd_cnt + 1'b1;

            if (state == S_START) idx <= '0;
            if (state == S_COLLECT && i_result_en) begin
                res_mem[idx] <= i_result;
                idx          <= idx + 1'b1;
            end

            decide_pend <= (state == S_DECIDE);
            if (state == S_DECIDE) argmax_q <= argmax_c;

            o_class_vld <= decide_pend;
            if (decide_pend) begin
                o_class      <= argmax_q;
                o_stable_cnt <= cnt_nxt;
                o_frame_cnt  <= o_frame_cnt + 16'd1;
                if (cnt_nxt == 4'(STABLE_MIN)) o_class_stable <= argmax_q;
            end
        end
    end

endmodule

// File: tb/tb_ml_frame_sequencer.sv
// Scoreboard bench for ml_frame_sequencer: a reference model pushes expected
// decisions when a frame is driven, and a monitor pops them on o_class_vld.
module tb_ml_frame_sequencer;

    localparam int STABLE_MIN = 2;

    typedef int frame_t [4];
    typedef struct {
        logic [1:0]  cls;
        logic [1:0]  stab;
        logic [3:0]  cnt;
        logic [15:0] fcnt;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_load_done, i_ml_rdy, i_pause, i_rd_done, i_result_en;
    logic [15:0] i_result;
    logic        o_rd_req, o_start, o_class_vld, o_busy, o_timeout, o_err;
    logic [1:0]  o_class, o_class_stable;
    logic [3:0]  o_stable_cnt;
    logic [15:0] o_frame_cnt;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb [$];
    exp_t mon_e;

    int m_class = 0, m_stable = 0, m_cnt = 0, m_fcnt = 0;

    ml_frame_sequencer #(
        .N_CLASS(4), .CLS_W(2), .RES_W(16), .STABLE_MIN(STABLE_MIN),
        .TO_W(24), .TIMEOUT(24'd64)
    ) dut (
        .clk(clk), .resetn(resetn),
        .i_load_done(i_load_done), .i_ml_rdy(i_ml_rdy), .i_pause(i_pause),
        .o_rd_req(o_rd_req), .i_rd_done(i_rd_done), .o_start(o_start),
        .i_result_en(i_result_en), .i_result(i_result),
        .o_class(o_class), .o_class_vld(o_class_vld),
        .o_class_stable(o_class_stable), .o_stable_cnt(o_stable_cnt),
        .o_busy(o_busy), .o_timeout(o_timeout), .o_err(o_err),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int ref_argmax(input frame_t r);
        int best = 0;
        for (int i = 1; i < 4; i++) if (r[i] > r[best]) best = i;
        return best;
    endfunction

    always @(negedge clk) begin
        if (resetn && o_class_vld) begin
            if (sb.size() == 0) begin
                check("vld_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("class",        32'(o_class),        32'(mon_e.cls));
                check("class_stable", 32'(o_class_stable), 32'(mon_e.stab));
                check("stable_cnt",   32'(o_stable_cnt),   32'(mon_e.cnt));
                check("frame_cnt",    32'(o_frame_cnt),    32'(mon_e.fcnt));
                check("vld_latency",  32'(cyc),            32'(mon_e.cyc));
            end
        end
    end

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        check("vld_one_cycle", 32'(o_class_vld), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_class"},  32'(o_class),        32'd0);
        check({tag, "_stable"}, 32'(o_class_stable), 32'd0);
        check({tag, "_cnt"},    32'(o_stable_cnt),   32'd0);
        check({tag, "_fcnt"},   32'(o_frame_cnt),    32'd0);
        check({tag, "_err"},    32'(o_err),          32'd0);
        check({tag, "_busy"},   32'(o_busy),         32'd0);
        check({tag, "_rdreq"},  32'(o_rd_req),       32'd0);
        check({tag, "_start"},  32'(o_start),        32'd0);
        check({tag, "_vld"},    32'(o_class_vld),    32'd0);
        check({tag, "_to"},     32'(o_timeout),      32'd0);
    endtask

    // Runs one frame; abort_after > 0 pulses reset after that many words instead of finishing.
    task automatic run_frame(input frame_t r, input int rd_delay, input bit gap,
                             input bit pause_mid, input int abort_after);
        int cls;
        exp_t e;
        i_load_done = 1'b1;
        for (int n = 0; n < 20 && !o_rd_req; n++) @(negedge clk);
        check("rd_req_rise", 32'(o_rd_req), 32'd1);
        if (!o_rd_req) return;
        i_load_done = 1'b0;
        repeat (rd_delay) @(negedge clk);
        check("rd_req_hold", 32'(o_rd_req), 32'd1);
        i_rd_done = 1'b1;
        @(negedge clk);
        i_rd_done = 1'b0;
        check("rd_req_drop", 32'(o_rd_req),  32'd0);
        check("start_pulse", 32'(o_start),   32'd1);
        check("no_timeout",  32'(o_timeout), 32'd0);
        @(negedge clk);
        check("start_end", 32'(o_start), 32'd0);
        for (int k = 0; k < 4; k++) begin
            if (abort_after > 0 && k == abort_after) begin
                resetn = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
                reset_checks("mid_rst");
                m_class = 0; m_stable = 0; m_cnt = 0; m_fcnt = 0;
                return;
            end
            i_result_en = 1'b1;
            i_result    = 16'(r[k]);
            @(negedge clk);
            i_result_en = 1'b0;
            if (pause_mid && k == 0) i_pause = 1'b1;
            if (gap && k == 1) @(negedge clk);
        end
        cls = ref_argmax(r);
        if (cls == m_class && m_fcnt != 0) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
        else                               m_cnt = 0;
        if (m_cnt == STABLE_MIN) m_stable = cls;
        m_class = cls;
        m_fcnt  = (m_fcnt + 1) & 16'hFFFF;
        e.cls  = 2'(cls);
        e.stab = 2'(m_stable);
        e.cnt  = 4'(m_cnt);
        e.fcnt = 16'(m_fcnt);
        e.cyc  = cyc + 2;
        sb.push_back(e);
        drain();
    endtask

    initial begin
        int e0;
        resetn = 1'b0; i_load_done = 1'b0; i_ml_rdy = 1'b1; i_pause = 1'b0;
        i_rd_done = 1'b0; i_result_en = 1'b0; i_result = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        reset_checks("por");

        // Basic frame
        run_frame('{100, -5, 300, 20}, 5, 1'b0, 1'b0, 0);
        check("basic_class", 32'(o_class), 32'd2);
        check("basic_fcnt",  32'(o_frame_cnt), 32'd1);

        // Stability: argmax 1,1,1 then 3
        run_frame('{0, 50, 1, 2}, 2, 1'b1, 1'b0, 0);
        check("stab1_cnt", 32'(o_stable_cnt), 32'd0);
        run_frame('{-1, 9, 3, 3}, 1, 1'b0, 1'b0, 0);
        check("stab2_cnt", 32'(o_stable_cnt), 32'd1);
        run_frame('{7, 8, -9, 0}, 3, 1'b0, 1'b0, 0);
        check("stab3_cnt", 32'(o_stable_cnt), 32'd2);
        check("stab3_stable", 32'(o_class_stable), 32'd1);
        run_frame('{1, 2, 3, 4}, 0, 1'b0, 1'b0, 0);
        check("stab4_cnt", 32'(o_stable_cnt), 32'd0);
        check("stab4_stable", 32'(o_class_stable), 32'd1);

        // Ties and negatives
        run_frame('{-7, -3, -3, -9}, 1, 1'b0, 1'b0, 0);
        check("tie_neg", 32'(o_class), 32'd1);
        run_frame('{5, 5, 5, 5}, 1, 1'b0, 1'b0, 0);
        check("tie_eq", 32'(o_class), 32'd0);
        run_frame('{-32768, 32767, -1, 0}, 1, 1'b0, 1'b0, 0);
        check("extremes", 32'(o_class), 32'd1);

        // Watchdog expiry with no readout done
        i_load_done = 1'b1;
        for (int n = 0; n < 20 && !o_rd_req; n++) @(negedge clk);
        check("to_rd_req", 32'(o_rd_req), 32'd1);
        e0 = cyc;
        i_load_done = 1'b0;
        for (int n = 0; n < 100 && !o_timeout; n++) @(negedge clk);
        check("to_pulse",   32'(o_timeout),   32'd1);
        check("to_latency", 32'(cyc - e0),    32'd64);
        check("to_err",     32'(o_err),       32'd1);
        check("to_rdreq",   32'(o_rd_req),    32'd0);
        check("to_fcnt",    32'(o_frame_cnt), 32'(m_fcnt));
        @(negedge clk);
        check("to_one_cycle", 32'(o_timeout), 32'd0);

        // rd_done on the expiry cycle wins; the frame then completes normally
        run_frame('{3, 1, 4, 1}, 63, 1'b0, 1'b0, 0);
        check("overlap_class", 32'(o_class), 32'd2);
        check("err_sticky",    32'(o_err),   32'd1);

        // Gating in IDLE
        i_pause = 1'b1; i_load_done = 1'b1;
        repeat (8) @(negedge clk);
        check("pause_idle_rdreq", 32'(o_rd_req), 32'd0);
        i_rd_done = 1'b1; i_result_en = 1'b1; i_result = 16'h7FFF;
        @(negedge clk);
        i_rd_done = 1'b0; i_result_en = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_busy", 32'(o_busy),      32'd0);
        check("stray_fcnt", 32'(o_frame_cnt), 32'(m_fcnt));
        i_pause = 1'b0; i_load_done = 1'b0;
        i_ml_rdy = 1'b0; i_load_done = 1'b1;
        repeat (5) @(negedge clk);
        check("mlrdy_low_rdreq", 32'(o_rd_req), 32'd0);
        i_ml_rdy = 1'b1; i_load_done = 1'b0;

        // Pause raised mid-frame: the frame finishes, then no new request
        run_frame('{0, 0, 0, 9}, 2, 1'b0, 1'b1, 0);
        check("pause_mid_class", 32'(o_class), 32'd3);
        i_load_done = 1'b1;
        repeat (8) @(negedge clk);
        check("pause_after_rdreq", 32'(o_rd_req), 32'd0);
        i_pause = 1'b0; i_load_done = 1'b0;

        // Reset after two words, then a clean frame from scratch
        run_frame('{9, 9, 9, 9}, 1, 1'b0, 1'b0, 2);
        run_frame('{-1, -2, 10, -3}, 4, 1'b0, 1'b0, 0);
        check("post_rst_fcnt", 32'(o_frame_cnt), 32'd1);
        check("post_rst_err",  32'(o_err),       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench stalled");
    end

endmodule
